// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment display path.
package display_pkg;

    typedef enum logic [1:0] {BLANK_R, SHOW_R, BLANK_L, SHOW_L} disp_state_t;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [1:0] ANODE_OFF = 2'b11;
    localparam logic [1:0] ANODE_R   = 2'b10;
    localparam logic [1:0] ANODE_L   = 2'b01;

endpackage

// File: rtl/display_mux_if.sv
// Digit value in, multiplexed display drive out.
interface display_mux_if;
    logic [7:0] val;
    logic [6:0] seg;
    logic [1:0] anode;
    logic       frame_tick;

    modport master (output val, input seg, anode, frame_tick);
    modport slave  (input val, output seg, anode, frame_tick);
endinterface

// File: rtl/display_mux_seven_seg_decoder.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module seven_seg_decoder (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/display_mux.sv
// Time-multiplexes a two-digit value onto a dual common-anode display with
// blanking dead-time between slots; val is snapshotted once per frame.
module display_mux
    import display_pkg::*;
#(
    parameter int SHOW_CYC  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic          clk,
    input  logic          reset,
    display_mux_if.slave  disp
);
    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    disp_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       shadow, shadow_d;
    logic [6:0]       seg_q, seg_d, dec_seg;
    logic [1:0]       anode_q, anode_d;
    logic [3:0]       nib;
    logic             last, snap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BLANK_R;
            cnt     <= '0;
            shadow  <= 8'h00;
            seg_q   <= SEG_OFF;
            anode_q <= ANODE_OFF;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            shadow  <= shadow_d;
            seg_q   <= seg_d;
            anode_q <= anode_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        last    = (state == SHOW_R || state == SHOW_L) ? (cnt == SHOW_LAST)
                                                      : (cnt == BLANK_LAST);
        if (last) begin
            cnt_d = '0;
            case (state)
                BLANK_R: state_d = SHOW_R;
                SHOW_R:  state_d = BLANK_L;
                BLANK_L: state_d = SHOW_L;
                SHOW_L:  state_d = BLANK_R;
                default: state_d = BLANK_R;
            endcase
        end
        snap     = (state == BLANK_R) && (cnt == '0);
        shadow_d = snap ? disp.val : shadow;
        // Decode from the post-snapshot value so a 1-cycle blank can't show a stale digit.
        nib      = (state_d == SHOW_L) ? shadow_d[7:4] : shadow_d[3:0];
    end

    seven_seg_decoder u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    always_comb begin
        seg_d   = SEG_OFF;
        anode_d = ANODE_OFF;
        case (state_d)
            SHOW_R: begin
                seg_d   = dec_seg;
                anode_d = ANODE_R;
            end
            SHOW_L: begin
                seg_d   = dec_seg;
                anode_d = ANODE_L;
            end
            default: begin
                seg_d   = SEG_OFF;
                anode_d = ANODE_OFF;
            end
        endcase
    end

    assign disp.seg        = seg_q;
    assign disp.anode      = anode_q;
    // Decoded from state so it is already high in the first cycle after reset drops.
    assign disp.frame_tick = ~reset && (state == BLANK_R) && (cnt == '0);

endmodule

// File: tb/tb_display_mux.sv
// Randomized check of display_mux against a frame-position reference model.
module tb_display_mux;
    localparam int SHOW  = 4;
    localparam int BLANK = 2;
    localparam int FRAME = 2 * (SHOW + BLANK);

    logic clk = 1'b0;
    logic reset;
    display_mux_if bus ();

    display_mux #(.SHOW_CYC(SHOW), .BLANK_CYC(BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] dec_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int total = 0;
    int bad   = 0;
    int t_rel = 0;
    int cyc   = 0;
    int last_tick = -1;
    logic [7:0] m_shadow = 8'h00;
    logic [6:0] obs_seg;
    logic [1:0] obs_an;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t_rel);
        end
    endtask

    // Expected drive at a given position in the frame, for the frame's snapshot value.
    function automatic void model(input int pos, input logic [7:0] sh,
                                  output logic [1:0] an, output logic [6:0] sg);
        if (pos >= BLANK && pos < BLANK + SHOW) begin
            an = 2'b10; sg = dec_tbl[sh[3:0]];
        end else if (pos >= 2 * BLANK + SHOW) begin
            an = 2'b01; sg = dec_tbl[sh[7:4]];
        end else begin
            an = 2'b11; sg = 7'h7F;
        end
    endfunction

    // One running cycle: drive v, check at negedge, then advance past the next posedge.
    task automatic step(input logic [7:0] v);
        int pos;
        logic [1:0] e_an;
        logic [6:0] e_sg;
        bus.val = v;
        pos = t_rel % FRAME;
        @(negedge clk);
        model(pos, m_shadow, e_an, e_sg);
        obs_seg = bus.seg;
        obs_an  = bus.anode;
        chk("anode", {30'd0, bus.anode}, {30'd0, e_an});
        chk("seg", {25'd0, bus.seg}, {25'd0, e_sg});
        chk("tick", {31'd0, bus.frame_tick}, {31'd0, pos == 0});
        if (bus.anode == 2'b00) chk("anode_legal", {30'd0, bus.anode}, 32'd3);
        if (bus.anode == 2'b11) chk("blank_seg", {25'd0, bus.seg}, 32'h7F);
        if (bus.frame_tick) begin
            if (last_tick >= 0) chk("tick_period", cyc - last_tick, FRAME);
            last_tick = cyc;
        end
        if (pos == 0) m_shadow = v;
        @(posedge clk);
        #1;
        t_rel++;
        cyc++;
    endtask

    initial begin
        reset   = 1'b1;
        bus.val = 8'h3A;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
            chk("rst_anode", {30'd0, bus.anode}, 32'd3);
            chk("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b0;
        t_rel = 0;

        // Two frames on 3A, val switches to 5F at t=19 (frame 1 pos 7), then frame 2.
        for (int t = 0; t < 3 * FRAME; t++) begin
            step((t >= FRAME + 7) ? 8'h5F : 8'h3A);
            if (t == 3)             chk("frame0_r_A", {25'd0, obs_seg}, 32'b0001000);
            if (t == 9)             chk("frame0_l_3", {25'd0, obs_seg}, 32'b0110000);
            if (t == FRAME + 9)     chk("no_tear_3", {25'd0, obs_seg}, 32'b0110000);
            if (t == 2 * FRAME + 3) chk("new_r_F", {25'd0, obs_seg}, 32'b0001110);
            if (t == 2 * FRAME + 9) chk("new_l_5", {25'd0, obs_seg}, 32'b0010010);
        end

        // Nibble sweep; val is scrambled after the snapshot cycle to expose tearing.
        for (int n = 0; n < 16; n++) begin
            for (int p = 0; p < FRAME; p++)
                step((p == 0) ? {4'($urandom_range(15)), 4'(n)} : 8'($urandom));
        end

        // Reset at pos 4 (mid SHOW_R).
        for (int p = 0; p < 4; p++) step(8'hC7);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tick", {31'd0, bus.frame_tick}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_anode", {30'd0, bus.anode}, 32'd3);
        chk("midrst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("midrst_shadow", {24'd0, dut.shadow}, 32'd0);
        chk("midrst_tick2", {31'd0, bus.frame_tick}, 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        t_rel     = 0;
        last_tick = -1;
        cyc       = 0;

        for (int i = 0; i < 1000 * FRAME; i++) step(8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
